bullet_hit_scanner: RTL

//  Downstream consumer of the bullet table. Once per frame it walks every bullet

---
 rtl/bullet_hit_scanner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bullet_hit_scanner.sv
// bullet_hit_scanner
//  Once per frame, walks every bullet slot through the bullet table's collision
//  read index and tests each rendered bullet against the player hitbox. A hit
//  strobes the table's collide input for that slot and takes DAMAGE off HP.
// Ports
//  clk, rst_n        clock, asynchronous active-low reset
//  start             frame tick, begins a scan (sampled in IDLE only)
//  revive            reload HP and abort any scan
//  player_pos/size   player box, {x,y} / {w,h}
//  bullet_index      collision read index into the bullet table
//  bullet_pos/size   table entry at bullet_index, {x,y} / {w,h}
//  bullet_render     table render bit at bullet_index
//  is_collide        one-cycle clear strobe for slot bullet_index
//  hp, dead          current HP and hp==0 flag
//  hit_count         hits counted in the last completed scan
//  busy, done        scan in progress / one-cycle scan-complete pulse
module bullet_hit_scanner #(
  parameter int unsigned N_BULLETS = 3,
  parameter logic [7:0]  DAMAGE    = 8'd1,
  parameter logic [7:0]  HP_INIT   = 8'd20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        revive,
  input  logic [15:0] player_pos,
  input  logic [15:0] player_size,
  output logic [2:0]  bullet_index,
  input  logic [15:0] bullet_pos,
  input  logic [15:0] bullet_size,
  input  logic        bullet_render,
  output logic        is_collide,
  output logic [7:0]  hp,
  output logic        dead,
  output logic [2:0]  hit_count,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] LAST_IDX = 3'(N_BULLETS - 1);
  localparam logic [2:0] CNT_MAX  = 3'd7;

  typedef enum logic [1:0] {IDLE, SCAN, HIT, DONE} state_t;

  state_t     state;
  logic [2:0] run_cnt;

  // Far edges in 9 bits so a box near 255 cannot wrap back onto the origin.
  logic [8:0] px_end, py_end, bx_end, by_end;
  logic       hit;

  assign px_end = 9'(player_pos[15:8]) + 9'(player_size[15:8]);
  assign py_end = 9'(player_pos[7:0])  + 9'(player_size[7:0]);
  assign bx_end = 9'(bullet_pos[15:8]) + 9'(bullet_size[15:8]);
  assign by_end = 9'(bullet_pos[7:0])  + 9'(bullet_size[7:0]);

  // Strict compares: boxes that merely share an edge do not overlap.
  assign hit = bullet_render
             & (9'(bullet_pos[15:8]) < px_end) & (9'(player_pos[15:8]) < bx_end)
             & (9'(bullet_pos[7:0])  < py_end) & (9'(player_pos[7:0])  < by_end);

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bullet_index <= 3'd0;
      is_collide   <= 1'b0;
      hp           <= HP_INIT;
      dead         <= 1'b0;
      hit_count    <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      run_cnt      <= 3'd0;
    end else if (revive) begin
      // Abort wins over everything; hit_count keeps the last completed scan.
      state        <= IDLE;
      bullet_index <= 3'd0;
      is_collide   <= 1'b0;
      hp           <= HP_INIT;
      dead         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      run_cnt      <= 3'd0;
    end else begin
      is_collide <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !dead) begin
            state        <= SCAN;
            busy         <= 1'b1;
            bullet_index <= 3'd0;
            run_cnt      <= 3'd0;
          end
        end
        SCAN: begin
          if (hit) begin
            // Index is held so the strobe lands on the slot that hit.
            state      <= HIT;
            is_collide <= 1'b1;
          end else if (bullet_index == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            bullet_index <= bullet_index + 3'd1;
          end
        end
        HIT: begin
          hp   <= (hp > DAMAGE) ? (hp - DAMAGE) : 8'd0;
          dead <= (hp <= DAMAGE);
          if (run_cnt != CNT_MAX) run_cnt <= run_cnt + 3'd1;
          if (bullet_index == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state        <= SCAN;
            bullet_index <= bullet_index + 3'd1;
          end
        end
        DONE: begin
          hit_count <= run_cnt;
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
